// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch stage is the master: it issues word requests and receives
// in-order responses.
interface if_fetch_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches to a
// variable-latency in-order memory, buffers responses with their pc+4 in a
// small FIFO, and squashes in-flight fetches on a redirect.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hazard_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    if_fetch_stage_if.master imem,
    output logic             valid_o,
    output logic [31:0]      pc_add4_o,
    output logic [31:0]      instruction_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] head, tail;
    logic [PW-1:0] tag_head, tag_tail;
    logic [31:0]   fifo_pc4   [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   tag_mem    [DEPTH];

    logic          pop, fire, push, drop, req;
    logic [CW:0]   credits;
    logic [31:0]   target;

    assign valid_o = (count != '0);
    assign pop     = valid_o & ~hazard_i;
    // Slots already claimed once this cycle's pop is accounted for; a pop frees
    // a slot immediately so a full FIFO can still stream at one per cycle.
    assign credits = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
    assign req     = ~redirect_i & (credits < (CW+1)'(DEPTH));
    assign fire    = req & imem.imem_gnt_i;
    assign drop    = imem.imem_rvalid_i & (discard != '0);
    assign push    = imem.imem_rvalid_i & ~redirect_i & (discard == '0);
    assign target  = redirect_pc_i & 32'hFFFF_FFFC;

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = pc;

    // Control state: PC, credit counters, FIFO and tag-queue pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            tag_head    <= '0;
            tag_tail    <= '0;
        end else if (redirect_i) begin
            // Everything still in flight is doomed, including a response that
            // lands in this very cycle (it is dropped, not counted).
            pc          <= target;
            outstanding <= outstanding - CW'(imem.imem_rvalid_i);
            discard     <= outstanding - CW'(imem.imem_rvalid_i);
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            tag_head    <= '0;
            tag_tail    <= '0;
        end else begin
            if (fire) begin
                pc       <= pc + 32'd4;
                tag_tail <= ptr_inc(tag_tail);
            end
            outstanding <= outstanding + CW'(fire) - CW'(imem.imem_rvalid_i);
            if (drop) begin
                discard <= discard - 1'b1;
            end
            if (push) begin
                tail     <= ptr_inc(tail);
                tag_head <= ptr_inc(tag_head);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage: pc+4 tags at grant time, {tag, word} at response time.
    always_ff @(posedge clk_i) begin
        if (fire) begin
            tag_mem[tag_tail] <= pc + 32'd4;
        end
        if (push) begin
            fifo_pc4[tail]   <= tag_mem[tag_head];
            fifo_instr[tail] <= imem.imem_rdata_i;
        end
    end

    // Head presentation; a NOP with zero pc+4 whenever nothing is buffered.
    always_comb begin
        pc_add4_o     = '0;
        instruction_o = '0;
        if (valid_o) begin
            pc_add4_o     = fifo_pc4[head];
            instruction_o = fifo_instr[head];
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: behavioural in-order memory with
// configurable grant/latency, scoreboard of expected {pc+4, instr}, plus a
// second instance with RESET_PC near the top of the address space.
module tb_if_fetch_stage;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hz, rd;
    logic [31:0] rd_pc;
    logic        valid;
    logic [31:0] pc4, instr;

    logic        w_zero = 1'b0;
    logic [31:0] w_zpc  = 32'h0;
    logic        wvalid;
    logic [31:0] wpc4, winstr;

    if_fetch_stage_if bus ();
    if_fetch_stage_if wbus ();

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .hazard_i(hz), .redirect_i(rd),
        .redirect_pc_i(rd_pc), .imem(bus), .valid_o(valid),
        .pc_add4_o(pc4), .instruction_o(instr)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
        .clk_i(clk), .rst_i(rst), .hazard_i(w_zero), .redirect_i(w_zero),
        .redirect_pc_i(w_zpc), .imem(wbus), .valid_o(wvalid),
        .pc_add4_o(wpc4), .instruction_o(winstr)
    );

    typedef struct packed { logic [31:0] addr; int due; } mreq_t;
    typedef struct packed { logic [31:0] pc4; logic [31:0] ins; } exp_t;

    mreq_t       mem_q[$];
    exp_t        sb[$];
    logic [31:0] m_pc;
    int          m_out, m_disc, m_cnt;
    int          cyc, lat, gmode;
    logic        g, rv;
    logic        chk_target;
    logic [31:0] tgt;
    logic        w_pend, wchk;
    logic [31:0] w_addr;
    int          wcyc;
    logic [31:0] wtab [3];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic model_reset();
        m_pc   = 32'h0;
        m_out  = 0;
        m_disc = 0;
        m_cnt  = 0;
        cyc    = 0;
        sb.delete();
        mem_q.delete();
    endtask

    // One clock cycle, entered and left at 1 time unit after the rising edge.
    task automatic cycle();
        logic p, exp_req, grant;
        int   l;
        g  = (gmode == 1) || (gmode == 2 && $urandom_range(0, 1) == 1);
        rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        bus.imem_gnt_i    = g;
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rv ? memdata(mem_q[0].addr) : 32'hBAD0_BAD0;
        wbus.imem_gnt_i    = 1'b1;
        wbus.imem_rvalid_i = w_pend;
        wbus.imem_rdata_i  = memdata(w_addr);
        @(negedge clk);
        p       = (m_cnt > 0) && !hz;
        exp_req = !rd && ((m_out + m_cnt - (p ? 1 : 0)) < DEPTH);
        check("req", bus.imem_req_o, exp_req);
        check("addr", bus.imem_addr_o, m_pc);
        check("valid", valid, m_cnt > 0);
        if (m_cnt > 0 && sb.size() > 0) begin
            check("pc4", pc4, sb[0].pc4);
            check("instr", instr, sb[0].ins);
            if (chk_target) begin
                check("tgt_pc4", pc4, tgt + 32'd4);
                check("tgt_instr", instr, memdata(tgt));
                chk_target = 1'b0;
            end
        end else if (m_cnt == 0) begin
            check("nop", instr, 32'h0);
        end
        if (wchk && wcyc < 3) begin
            check("w_req", wbus.imem_req_o, 1);
            check("w_addr", wbus.imem_addr_o, wtab[wcyc]);
        end
        if (wchk && wcyc >= 2 && wcyc < 5) begin
            check("w_valid", wvalid, 1);
            check("w_pc4", wpc4, wtab[wcyc-2] + 32'd4);
            check("w_instr", winstr, memdata(wtab[wcyc-2]));
        end
        w_pend = wbus.imem_req_o;
        w_addr = wbus.imem_addr_o;
        wcyc++;
        grant = exp_req && g;
        if (rd) begin
            if (rv) mem_q.delete(0);
            m_disc = m_out - (rv ? 1 : 0);
            m_out  = m_disc;
            m_cnt  = 0;
            sb.delete();
            m_pc   = rd_pc & 32'hFFFF_FFFC;
        end else begin
            if (rv) begin
                mem_q.delete(0);
                m_out--;
                if (m_disc > 0) m_disc--;
                else m_cnt++;
            end
            if (p) begin
                sb.delete(0);
                m_cnt--;
            end
            if (grant) begin
                l = (gmode == 2) ? int'($urandom_range(1, 3)) : lat;
                mem_q.push_back('{addr: m_pc, due: cyc + l});
                sb.push_back('{pc4: m_pc + 32'd4, ins: memdata(m_pc)});
                m_pc = m_pc + 32'd4;
                m_out++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic quiet_mem();
        bus.imem_gnt_i     = 1'b0;
        bus.imem_rvalid_i  = 1'b0;
        bus.imem_rdata_i   = 32'h0;
        wbus.imem_gnt_i    = 1'b0;
        wbus.imem_rvalid_i = 1'b0;
        wbus.imem_rdata_i  = 32'h0;
        w_pend = 1'b0;
        w_addr = 32'h0;
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", valid, 0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc4", pc4, 32'h0);
        check("rst_addr", bus.imem_addr_o, 32'h0);
        check("rst_waddr", wbus.imem_addr_o, 32'hFFFF_FFF8);
        check("rst_wvalid", wvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int found;
        wtab[0] = 32'hFFFF_FFF8;
        wtab[1] = 32'hFFFF_FFFC;
        wtab[2] = 32'h0000_0000;
        rst = 1'b1; hz = 1'b0; rd = 1'b0; rd_pc = 32'h0;
        gmode = 1; lat = 1; chk_target = 1'b0; tgt = 32'h0;
        wchk = 1'b1; wcyc = 0;
        quiet_mem();
        model_reset();
        #3;
        check_reset_outputs();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        wcyc = 0;

        // Streaming with a single-cycle memory, grant always high.
        repeat (12) cycle();

        // Three stalled cycles mid-stream, then resume.
        hz = 1'b1;
        repeat (3) cycle();
        hz = 1'b0;
        repeat (6) cycle();

        // Redirect while two fetches are outstanding on a 3-cycle memory.
        lat = 3;
        repeat (8) cycle();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (m_out == 2 && mem_q.size() > 0 && mem_q[0].due > cyc) found = 1;
            else cycle();
        end
        check("rd_setup", found, 1);
        rd = 1'b1; rd_pc = 32'h0000_0103; tgt = 32'h0000_0100; chk_target = 1'b1;
        cycle();
        rd = 1'b0;
        check("discard2", dut.discard, 2);
        repeat (12) cycle();
        check("tgt_seen", chk_target, 0);

        // Redirect coinciding with the only outstanding response.
        gmode = 0;
        repeat (6) cycle();
        lat = 2; gmode = 1;
        cycle();
        check("one_out", m_out, 1);
        gmode = 0;
        cycle();
        rd = 1'b1; rd_pc = 32'h0000_0200; tgt = 32'h0000_0200; chk_target = 1'b1;
        cycle();
        rd = 1'b0;
        check("discard0", dut.discard, 0);
        check("outst0", dut.outstanding, 0);
        gmode = 1; lat = 1;
        repeat (10) cycle();
        check("tgt2_seen", chk_target, 0);

        // Random grant/latency/hazard/redirect traffic.
        gmode = 2;
        for (int i = 0; i < 200; i++) begin
            hz    = ($urandom_range(0, 3) == 0);
            rd    = ($urandom_range(0, 19) == 0);
            rd_pc = $urandom;
            cycle();
        end
        hz = 1'b0; rd = 1'b0;

        // Asynchronous reset mid-cycle, then restart from RESET_PC.
        #2 rst = 1'b1;
        #1;
        check_reset_outputs();
        quiet_mem();
        wchk = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 60; i++) begin
            hz = ($urandom_range(0, 3) == 0);
            cycle();
        end
        hz = 1'b0; gmode = 1; lat = 1;
        repeat (20) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the 5-stage pipeline. It owns the PC, issues word fetches to a variable-latency in-order instruction memory, and buffers the returned instructions in a small FIFO. It presents `{pc_add4, instruction}` to the IF/ID pipeline register, holds them while the hazard unit stalls, and squashes all in-flight fetches on a branch/jump redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 2, minimum 2: FIFO entries, and also the cap on (outstanding fetches + buffered entries).

- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `hazard_i` input 1: stall from the hazard unit; the FIFO head is not consumed.
- `redirect_i` input 1: taken branch/jump; the same pulse that flushes IF/ID.
- `redirect_pc_i` input 32: redirect target; bits [1:0] are ignored and treated as 00.
- `imem_req_o` output 1: fetch request.
- `imem_addr_o` output 32: fetch address, equal to the PC register.
- `imem_gnt_i` input 1: memory accepts the request this cycle.
- `imem_rvalid_i` input 1: response valid; responses arrive in request order, at least 1 cycle after the grant.
- `imem_rdata_i` input 32: response instruction word.
- `valid_o` input-facing output 1: FIFO head is valid.
- `pc_add4_o` output 32: address of the head instruction + 4.
- `instruction_o` output 32: head instruction; 32'h0 (NOP) when `valid_o`=0.

## Operation
- State:
  - `pc` (32 bits).
  - `outstanding`: granted fetches not yet answered, including doomed ones.
  - `discard`: responses still to drop.
  - FIFO of `DEPTH` entries, each `{pc_add4, instr}`, with its count.
- Fetch handshake:
  - `pop` = `valid_o & ~hazard_i`.
  - `imem_req_o` = `~redirect_i & (outstanding + count - pop < DEPTH)`. This path is combinational from `hazard_i` and `redirect_i`.
  - On `imem_req_o & imem_gnt_i`: `pc` <= `pc + 4` (mod 2^32), `outstanding` +1, and the entry's `pc_add4` = issued address + 4, recorded in an in-order tag queue of `DEPTH` entries.
  - `imem_req_o` may drop without a grant; the memory must tolerate this.
- Response handling, on `imem_rvalid_i`:
  - `outstanding` -1.
  - If `discard` > 0: decrement `discard` and drop the data.
  - Otherwise push `{tag, imem_rdata_i}` into the FIFO. The credit rule guarantees space.
- Consume: on `pop`, advance the FIFO head.
- Redirect, on `redirect_i`. Redirect takes priority over hazard, grant and response:
  - `pc` <= `{redirect_pc_i[31:2], 2'b00}`.
  - FIFO and tag queue are cleared.
  - `discard` <= `outstanding - imem_rvalid_i`; a response arriving in the redirect cycle is dropped.
  - No request is made in the redirect cycle. The first request to the target is in the next cycle.
- Arithmetic:
  - All PC math is 32-bit wrap-around; 32'hFFFF_FFFC + 4 = 0.
  - Counter widths are `$clog2(DEPTH+1)`. Counters never overflow by construction.
- Reset (asynchronous):
  - `pc` = `RESET_PC`; counters, FIFO and tag queue are empty.
  - Outputs: `valid_o`=0, `instruction_o`=0, `pc_add4_o`=0, `imem_addr_o`=`RESET_PC`.
  - `imem_req_o`=1 from the first cycle after reset deasserts.
  - The instruction memory shares `rst_i`; no pre-reset response may arrive after reset.

## Timing
- Outputs `valid_o`, `pc_add4_o` and `instruction_o` come from FIFO registers, with no combinational path from `imem_*`.
- Fetch latency, with grant in cycle t and response in t+1: `valid_o` rises in t+2.
- Throughput: one instruction per cycle sustained with `DEPTH`=2 and a single-cycle memory.
- While `hazard_i`=1, outputs hold stable; fetching continues until credits run out.
- Redirect in cycle t:
  - `valid_o`=0 in t+1.
  - Request to the target in t+1.
  - Earliest valid target instruction in t+3.
- FIFO full plus a simultaneous pop and push: both occur; `count` is unchanged.

## Test plan
- Reset, then a 1-cycle memory with `gnt` tied to 1 and no hazards:
  - required: `imem_addr_o` = 0, 4, 8, … on consecutive cycles;
  - required: `valid_o`=1 continuously from cycle 2;
  - required: `pc_add4_o` = 4, 8, 12, … with the matching memory data.
- `hazard_i`=1 for 3 cycles while streaming:
  - required: `instruction_o`/`pc_add4_o` frozen;
  - required: `imem_req_o` drops once `outstanding + count` = 2;
  - required: the stream resumes without loss or duplication.
- `redirect_i` with `redirect_pc_i`=32'h0000_0103 while 2 fetches are outstanding on a 3-cycle-latency memory:
  - required: both stale responses are dropped;
  - required: the next valid output is the word at 32'h100, with `pc_add4_o`=32'h104.
- Redirect in the same cycle as `imem_rvalid_i`, with 1 fetch outstanding:
  - required: that response is dropped and `discard`=0;
  - required: the next valid output is the target instruction.
- `RESET_PC`=32'hFFFF_FFF8 with no hazards:
  - required: fetch addresses are FFFF_FFF8, FFFF_FFFC, 0000_0000;
  - required: `pc_add4_o` values are FFFF_FFFC, 0, 4.
- Random `gnt`/`rvalid` delays with `rst_i` asserted mid-stream:
  - required: all outputs return to their reset values asynchronously;
  - required: fetch restarts at `RESET_PC`.
